gps_tx_buffer: RTL and testbench
================================

# gps_tx_buffer

Transmit-side byte buffer for the GPS UART link. The host side loads up to 64 bytes as 32-bit words by word address. On command, the block streams them in order to the UART transmitter using a start/busy handshake. It sits between the host register interface and the UART TX core, and is the outbound counterpart of the GPS receive buffer.

## Interface
- ACK_TIMEOUT, default 1000: cycles to wait in WAIT_ACK for the transmitter's busy flag to rise before the byte is counted as sent.
- clock_50mhz  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_en  in  1  word write strobe; honoured only in IDLE.
- address_in  in  4  word address; byte base = address_in*4.
- write_data  in  32  [7:0] to byte base+0, [15:8] to +1, [23:16] to +2, [31:24] to +3.
- send  in  1  level-sampled start command; honoured only in IDLE.
- send_length  in  7  number of bytes to send; 0 is a no-op, values above 64 are clamped to 64.
- tx_busy  in  1  UART TX busy flag, asynchronous to this block.
- tx_data  out  8  byte presented to the UART TX.
- tx_start  out  1  one-cycle start pulse to the UART TX.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- bytes_sent  out  7  bytes completed in the current or last frame.

## Operation
- Storage: 64 x 8 byte array. It is not reset; contents are undefined until written.
- tx_busy passes through a 2-flop synchronizer (reset to 0) to give busy_s. Only busy_s is used internally.
- Internal registers: len (7b), idx (6b), ack timer (sized for ACK_TIMEOUT).
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, FINISH.
  - IDLE: write_en performs the word write. If send=1 and send_length≠0: latch len=min(send_length,64), idx=0, bytes_sent=0, busy=1, go to LOAD. If send_length=0: stay in IDLE, no outputs change.
  - LOAD: tx_data<=buffer[idx]; go to START.
  - START: tx_start<=1, timer cleared; go to WAIT_ACK.
  - WAIT_ACK: tx_start<=0. If busy_s=1, go to WAIT_DONE. If timer reaches ACK_TIMEOUT-1, go to WAIT_DONE anyway (the byte is treated as sent).
  - WAIT_DONE: when busy_s=0, bytes_sent<=bytes_sent+1. If idx+1==len, go to FINISH; otherwise idx<=idx+1 and go to LOAD.
  - FINISH: done<=1 for one cycle, busy<=0; go to IDLE.
- Simultaneous write_en and send in IDLE: the write commits on the same edge. The written data is the data sent.
- write_en and send outside IDLE are ignored; the buffer is frozen for the whole frame.
- idx never exceeds 63. There is no wrap within a frame.

## Timing
- Reset values: tx_data=0, tx_start=0, busy=0, done=0, bytes_sent=0, state=IDLE, synchronizer=0.
- reset_n low mid-frame: all outputs go to their reset values immediately (asynchronously). The frame is abandoned, with no done pulse.
- Let send be sampled at edge k:
  - busy rises after edge k.
  - tx_data is valid after edge k+1.
  - tx_start is high for exactly one cycle, between edges k+2 and k+3.
- tx_data stays stable from one cycle before tx_start until the next LOAD.
- Byte-to-byte gap: tx_busy fall to next tx_start is 2 sync cycles plus WAIT_DONE, LOAD and START, i.e. 5 cycles.
- done pulses in the cycle after the last WAIT_DONE exit. busy falls on the same edge that raises done.
- bytes_sent holds its final value until the next accepted send.

## Test plan
- Send four bytes: write 0x44332211 to address 0, send_length=4; a TX model holds tx_busy high for 20 cycles after each tx_start. Required: tx_data sequence 0x11, 0x22, 0x33, 0x44 at the four tx_start pulses; bytes_sent=4; done pulses once; busy is low afterwards.
- Zero length: send_length=0 with send=1. Required: no tx_start, busy stays 0, no done.
- Clamp: fill all 16 words with an incrementing pattern, send_length=100. Required: exactly 64 tx_start pulses, last byte = buffer[63], bytes_sent=64.
- Ack timeout: tx_busy tied low, ACK_TIMEOUT=16, send_length=2. Required: two tx_start pulses, the second arriving 16 + 4 cycles after the first; done pulses; no hang.
- Busy lockout: mid-frame, assert write_en to address 0 with 0xFFFFFFFF and assert send. Required: both are ignored, the original bytes are sent, and there is exactly one done.
- Async reset: pull reset_n low during WAIT_DONE of byte 2. Required: outputs are at reset values immediately, no done. After release, a new send of length 1 transmits buffer[0] normally.

Source files
------------

// File: rtl/gps_tx_buffer.sv
// gps_tx_buffer: 64-byte transmit buffer for the GPS UART link.
// The host loads 32-bit words by word address while the block is idle.
// A send command then streams the bytes in order to the UART TX core.
// The handshake is a one-cycle start pulse followed by waiting on the
// core's busy flag. A timeout guards against a busy flag that never rises.
module gps_tx_buffer #(
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic        clock_50mhz,
    input  logic        reset_n,
    input  logic        write_en,
    input  logic [3:0]  address_in,
    input  logic [31:0] write_data,
    input  logic        send,
    input  logic [6:0]  send_length,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        done,
    output logic [6:0]  bytes_sent
);

    localparam int TIMER_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [6:0]         MAX_LEN    = 7'd64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t               state_r;
    logic [7:0]           buffer_r [0:63];
    logic [1:0]           sync_r;
    logic [6:0]           len_r;
    logic [5:0]           idx_r;
    logic [TIMER_W-1:0]   timer_r;

    logic                 busy_s;
    logic                 write_ok_s;
    logic [6:0]           len_clamped_s;
    logic                 last_byte_s;

    assign busy_s      = sync_r[1];
    assign write_ok_s  = write_en && (state_r == IDLE);
    assign last_byte_s = (({1'b0, idx_r} + 7'd1) == len_r);

    // Clamp the requested frame length to the buffer size.
    always_comb begin
        len_clamped_s = send_length;
        if (send_length > MAX_LEN) begin
            len_clamped_s = MAX_LEN;
        end else begin
            len_clamped_s = send_length;
        end
    end

    // Byte storage: word writes only while idle, so it is frozen during a frame.
    always_ff @(posedge clock_50mhz) begin
        if (write_ok_s) begin
            buffer_r[{address_in, 2'b00}] <= write_data[7:0];
            buffer_r[{address_in, 2'b01}] <= write_data[15:8];
            buffer_r[{address_in, 2'b10}] <= write_data[23:16];
            buffer_r[{address_in, 2'b11}] <= write_data[31:24];
        end
    end

    // Two-flop synchronizer for the asynchronous UART busy flag.
    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], tx_busy};
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clock_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            len_r      <= 7'd0;
            idx_r      <= 6'd0;
            timer_r    <= '0;
            tx_data    <= 8'd0;
            tx_start   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bytes_sent <= 7'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (send && (send_length != 7'd0)) begin
                        len_r      <= len_clamped_s;
                        idx_r      <= 6'd0;
                        bytes_sent <= 7'd0;
                        busy       <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= buffer_r[idx_r];
                    state_r <= START;
                end
                START: begin
                    tx_start <= 1'b1;
                    timer_r  <= '0;
                    state_r  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    tx_start <= 1'b0;
                    if (busy_s) begin
                        state_r <= WAIT_DONE;
                    end else if (tx_start) begin
                        // The ack window is counted from the cycle after the start pulse.
                        timer_r <= '0;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r <= WAIT_DONE;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                WAIT_DONE: begin
                    if (!busy_s) begin
                        bytes_sent <= bytes_sent + 7'd1;
                        if (last_byte_s) begin
                            state_r <= FINISH;
                        end else begin
                            idx_r   <= idx_r + 6'd1;
                            state_r <= LOAD;
                        end
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_tx_buffer.sv
// Scoreboard bench for gps_tx_buffer: the stimulus pushes expected bytes and
// final byte counts, and a monitor pops and compares them at each tx_start/done.
module tb_gps_tx_buffer;

    localparam int ACK_TO = 16;

    logic        clock_50mhz = 1'b0;
    logic        reset_n     = 1'b0;
    logic        write_en    = 1'b0;
    logic [3:0]  address_in  = 4'd0;
    logic [31:0] write_data  = 32'd0;
    logic        send        = 1'b0;
    logic [6:0]  send_length = 7'd0;
    logic        tx_busy     = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic        done;
    logic [6:0]  bytes_sent;

    gps_tx_buffer #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clock_50mhz (clock_50mhz),
        .reset_n     (reset_n),
        .write_en    (write_en),
        .address_in  (address_in),
        .write_data  (write_data),
        .send        (send),
        .send_length (send_length),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .bytes_sent  (bytes_sent)
    );

    always #10 clock_50mhz = ~clock_50mhz;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int start_cnt = 0;
    int start_cyc [$];
    logic [7:0] exp_bytes [$];
    int exp_sent [$];
    bit model_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock_50mhz) cyc <= cyc + 1;

    // Monitor: pop expected byte at every tx_start and expected count at every done.
    always @(negedge clock_50mhz) begin
        if (reset_n) begin
            if (tx_start) begin
                start_cnt++;
                start_cyc.push_back(cyc);
                if (exp_bytes.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx_start: got tx_data %0h want no pulse", tx_data);
                end else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
                end
            end
            if (done) begin
                done_cnt++;
                if (exp_sent.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got bytes_sent %0d want no pulse", bytes_sent);
                end else begin
                    chk("done_bytes_sent", {25'd0, bytes_sent}, exp_sent.pop_front());
                    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    // UART TX model: busy high for 20 cycles after each start pulse.
    always @(negedge clock_50mhz) begin
        if (model_en && reset_n && tx_start) begin
            tx_busy = 1'b1;
            repeat (20) @(negedge clock_50mhz);
            tx_busy = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_50mhz);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock_50mhz);
        write_en   = 1'b1;
        address_in = a;
        write_data = d;
        @(negedge clock_50mhz);
        write_en   = 1'b0;
    endtask

    task automatic start_frame(input logic [6:0] n);
        @(negedge clock_50mhz);
        send        = 1'b1;
        send_length = n;
        @(negedge clock_50mhz);
        send        = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clock_50mhz);
            n++;
        end
        tick(1);
        chk(name, done_cnt, target);
    endtask

    task automatic wait_starts(input int target, input int budget, input string name);
        int n = 0;
        while (start_cnt < target && n < budget) begin
            @(negedge clock_50mhz);
            n++;
        end
        chk(name, start_cnt, target);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        logic [31:0] d;

        // Reset state
        tick(3);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bytes_sent", {25'd0, bytes_sent}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Four bytes, with edge-exact start timing
        wr(4'd0, 32'h4433_2211);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        exp_sent.push_back(4);
        start_cyc.delete();
        @(negedge clock_50mhz);
        send = 1'b1;
        send_length = 7'd4;
        @(posedge clock_50mhz); #1;
        send = 1'b0;
        chk("k_busy", {31'd0, busy}, 32'd1);
        chk("k_tx_start", {31'd0, tx_start}, 32'd0);
        @(posedge clock_50mhz); #1;
        chk("k1_tx_start", {31'd0, tx_start}, 32'd0);
        chk("k1_tx_data", {24'd0, tx_data}, 32'h11);
        @(posedge clock_50mhz); #1;
        chk("k2_tx_start", {31'd0, tx_start}, 32'd1);
        @(posedge clock_50mhz); #1;
        chk("k3_tx_start", {31'd0, tx_start}, 32'd0);
        wait_done(1, 400, "four_done");
        chk("four_busy_after", {31'd0, busy}, 32'd0);
        chk("four_bytes_sent", {25'd0, bytes_sent}, 32'd4);
        chk("four_queue_empty", exp_bytes.size(), 32'd0);
        chk("four_starts", start_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < start_cyc.size(); i++) begin
            chk("byte_period", start_cyc[i] - start_cyc[i-1], 32'd25);
        end
        tick(30);
        chk("four_single_done", done_cnt, 32'd1);

        // Zero length is a no-op
        s0 = start_cnt;
        start_frame(7'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        tick(30);
        chk("zero_no_start", start_cnt - s0, 32'd0);
        chk("zero_no_done", done_cnt, 32'd1);
        chk("zero_bytes_sent_held", {25'd0, bytes_sent}, 32'd4);

        // Clamp 100 -> 64 bytes
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(8'h40 + 4*w + b);
            wr(4'(w), d);
        end
        for (int i = 0; i < 64; i++) exp_bytes.push_back(8'(8'h40 + i));
        exp_sent.push_back(64);
        s0 = start_cnt;
        start_frame(7'd100);
        wait_done(2, 64 * 30, "clamp_done");
        chk("clamp_starts", start_cnt - s0, 32'd64);
        chk("clamp_bytes_sent", {25'd0, bytes_sent}, 32'd64);
        chk("clamp_queue_empty", exp_bytes.size(), 32'd0);

        // Ack timeout with tx_busy tied low
        model_en = 1'b0;
        tick(5);
        start_cyc.delete();
        exp_bytes.push_back(8'h40);
        exp_bytes.push_back(8'h41);
        exp_sent.push_back(2);
        start_frame(7'd2);
        wait_done(3, 200, "timeout_done");
        chk("timeout_starts", start_cyc.size(), 32'd2);
        if (start_cyc.size() == 2) chk("timeout_gap", start_cyc[1] - start_cyc[0], 32'd20);
        chk("timeout_bytes_sent", {25'd0, bytes_sent}, 32'd2);
        model_en = 1'b1;

        // Busy lockout: write and send mid-frame are ignored
        wr(4'd0, 32'h4433_2211);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        exp_sent.push_back(4);
        s0 = start_cnt;
        start_frame(7'd4);
        wait_starts(s0 + 1, 50, "lock_first_start");
        @(negedge clock_50mhz);
        write_en = 1'b1;
        address_in = 4'd0;
        write_data = 32'hFFFF_FFFF;
        send = 1'b1;
        send_length = 7'd4;
        @(negedge clock_50mhz);
        write_en = 1'b0;
        send = 1'b0;
        wait_done(4, 400, "lock_done");
        tick(60);
        chk("lock_single_done", done_cnt, 32'd4);
        chk("lock_starts", start_cnt - s0, 32'd4);

        // Async reset during WAIT_DONE of byte 2
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        exp_bytes.push_back(8'h33);
        exp_bytes.push_back(8'h44);
        s0 = start_cnt;
        start_frame(7'd4);
        wait_starts(s0 + 2, 100, "rst_second_start");
        tick(4);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("arst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_bytes_sent", {25'd0, bytes_sent}, 32'd0);
        exp_bytes.delete();
        tick(2);
        reset_n = 1'b1;
        tick(30);
        chk("arst_no_done", done_cnt, 32'd4);
        exp_bytes.push_back(8'h11);
        exp_sent.push_back(1);
        start_frame(7'd1);
        wait_done(5, 200, "arst_resend_done");
        chk("arst_resend_bytes_sent", {25'd0, bytes_sent}, 32'd1);
        chk("arst_resend_queue_empty", exp_bytes.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
